w_wb_queue: RTL and testbench

W_WB_QUEUE -- requirements
Module: w_wb_queue

---
 rtl/w_wb_queue_if.sv | 58 +++++
 rtl/w_wb_queue.sv | 175 +++++++++++++++++
 tb/tb_w_wb_queue.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/w_wb_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : w_wb_queue_if
//  Purpose  : Bundles the signals of the write-back queue. This covers the
//             producer request channel, the register-file write port and the
//             scoreboard query ports.
//  Modports : master - producer / environment side (drives requests,
//                      stall and scoreboard queries)
//             slave  - the queue itself
//  Signals  : in_valid/in_ready/in_addr/in_data/in_pc   request channel
//             gw_stall/gw_we/gw_addr/gw_data/gw_pc      register-file port
//             chk_addr1/2, chk_busy1/2                  scoreboard queries
//             q_count                                   occupancy
//  Revision : 1.0 - initial release
// ============================================================================
interface w_wb_queue_if #(
    parameter int DEPTH = 4
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    // Producer request channel
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_addr;
    logic [31:0]     in_data;
    logic [31:0]     in_pc;

    // Register-file write port
    logic            gw_stall;
    logic            gw_we;
    logic [4:0]      gw_addr;
    logic [31:0]     gw_data;
    logic [31:0]     gw_pc;

    // Scoreboard queries
    logic [4:0]      chk_addr1;
    logic [4:0]      chk_addr2;
    logic            chk_busy1;
    logic            chk_busy2;

    // Occupancy
    logic [c_CW-1:0] q_count;

    modport master (
        output in_valid, in_addr, in_data, in_pc,
        output gw_stall, chk_addr1, chk_addr2,
        input  in_ready, gw_we, gw_addr, gw_data, gw_pc,
        input  chk_busy1, chk_busy2, q_count
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_pc,
        input  gw_stall, chk_addr1, chk_addr2,
        output in_ready, gw_we, gw_addr, gw_data, gw_pc,
        output chk_busy1, chk_busy2, q_count
    );
endinterface
`default_nettype wire

// File: rtl/w_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : w_wb_queue
//  Purpose  : In-order write-back queue in front of a shared register-file
//             write port. Requests {addr, data, pc} are buffered in a FIFO.
//             The head entry is written whenever the port is not stalled by
//             another writer. A small scoreboard reports whether a write to
//             a queried register is still pending.
//  Ports    : clk    - sole clock, rising edge
//             reset  - asynchronous, active-low reset
//             bus    - w_wb_queue_if.slave (request, gw port, scoreboard,
//                      q_count)
//  Params   : DEPTH  - number of entries, power of two, 2..16
//  Options  : WBQ_BYPASS_EN - when defined, a request that arrives while the
//             queue is empty and the port is free is driven straight onto gw
//             in the same cycle instead of being stored.
//  Revision : 1.0 - initial release
// ============================================================================
module w_wb_queue #(
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    w_wb_queue_if.slave     bus
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [4:0]      r_addr [DEPTH];
    logic [31:0]     r_data [DEPTH];
    logic [31:0]     r_pc   [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [c_CW-1:0] r_count;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);

    // in_ready depends only on stored state, so a pop in the same cycle
    // never opens a slot for a push while full.
    assign bus.in_ready = ~w_full;
    assign w_accept     = bus.in_valid & ~w_full;

`ifdef WBQ_BYPASS_EN
    // An empty queue with a free port lets the request go straight through.
    assign w_bypass = bus.in_valid & (bus.in_addr != 5'd0) & w_empty & ~bus.gw_stall;
`else
    assign w_bypass = 1'b0;
`endif

    // Writes to r0 are acknowledged but dropped: they have no architectural
    // effect and must not occupy a slot or mark the scoreboard busy.
    assign w_push = w_accept & (bus.in_addr != 5'd0) & ~w_bypass;
    assign w_pop  = ~w_empty & ~bus.gw_stall;

    // ------------------------------------------------------------------
    // Register-file write port
    // ------------------------------------------------------------------
    always_comb begin
        bus.gw_we   = 1'b0;
        bus.gw_addr = 5'd0;
        bus.gw_data = 32'd0;
        bus.gw_pc   = 32'd0;
        if (w_pop) begin
            bus.gw_we   = 1'b1;
            bus.gw_addr = r_addr[r_head];
            bus.gw_data = r_data[r_head];
            bus.gw_pc   = r_pc[r_head];
        end else if (w_bypass) begin
            bus.gw_we   = 1'b1;
            bus.gw_addr = bus.in_addr;
            bus.gw_data = bus.in_data;
            bus.gw_pc   = bus.in_pc;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and valid bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase

            // head and tail can only coincide on a push+pop when the queue
            // is full, and pushes are blocked then, so the set and the clear
            // never hit the same bit.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pop && (r_head == c_AW'(i))) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_push && (r_tail == c_AW'(i))) begin
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry payload
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_addr[g] <= 5'd0;
                    r_data[g] <= 32'd0;
                    r_pc[g]   <= 32'd0;
                end else if (w_push && (r_tail == c_AW'(g))) begin
                    r_addr[g] <= bus.in_addr;
                    r_data[g] <= bus.in_data;
                    r_pc[g]   <= bus.in_pc;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scoreboard: any valid entry targeting the queried register.
    // r0 is never busy because it is never stored.
    // ------------------------------------------------------------------
    logic w_busy1;
    logic w_busy2;

    always_comb begin
        w_busy1 = 1'b0;
        w_busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == bus.chk_addr1)) begin
                w_busy1 = 1'b1;
            end
            if (r_valid[i] && (r_addr[i] == bus.chk_addr2)) begin
                w_busy2 = 1'b1;
            end
        end
    end

    assign bus.chk_busy1 = w_busy1 & (bus.chk_addr1 != 5'd0);
    assign bus.chk_busy2 = w_busy2 & (bus.chk_addr2 != 5'd0);
    assign bus.q_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_w_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_w_wb_queue
//  Purpose  : Self-checking bench for w_wb_queue (DEPTH = 4). A table of
//             per-cycle {inputs, expected outputs} records is walked first.
//             Hand-written sequences then cover latency, bypass, reset
//             during operation and the first push after reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_w_wb_queue;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    w_wb_queue_if #(.DEPTH(DEPTH)) bus ();

    w_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
        logic        st;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        rdy;
        logic        we;
        logic [4:0]  ga;
        logic [31:0] gd;
        logic [31:0] gp;
        logic        b1;
        logic        b2;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(
        input logic v, input logic [4:0] a, input logic [31:0] d,
        input logic [31:0] pc, input logic st,
        input logic [4:0] c1, input logic [4:0] c2,
        input logic rdy, input logic we, input logic [4:0] ga,
        input logic [31:0] gd, input logic [31:0] gp,
        input logic b1, input logic b2, input logic [2:0] cnt);
        vec_t r;
        r.v = v;   r.a = a;   r.d = d;   r.pc = pc; r.st = st;
        r.c1 = c1; r.c2 = c2; r.rdy = rdy; r.we = we; r.ga = ga;
        r.gd = gd; r.gp = gp; r.b1 = b1; r.b2 = b2; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc, input logic st,
                         input logic [4:0] c1, input logic [4:0] c2);
        bus.in_valid  = v;
        bus.in_addr   = a;
        bus.in_data   = d;
        bus.in_pc     = pc;
        bus.gw_stall  = st;
        bus.chk_addr1 = c1;
        bus.chk_addr2 = c2;
    endtask

    task automatic idle(input logic st);
        drive(1'b0, 5'd0, 32'd0, 32'd0, st, 5'd0, 5'd0);
    endtask

    // Watchdog: the bench only waits on its own clock, but never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Every push into an empty queue with a free port is either stalled
        // or to r0, so the table holds with and without bypass.
        //         v  a   d         pc         st c1 c2   rdy we ga  gd        gp        b1 b2 cnt
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   0, 0, 0,  1, 0, 0, 32'h0,  32'h0,   0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h1234, 32'h0,   0, 0, 0,  1, 0, 0, 32'h0,  32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   0, 0, 0,  1, 0, 0, 32'h0,  32'h0,   0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h11,   32'h100, 1, 0, 0,  1, 0, 0, 32'h0,  32'h0,   0, 0, 0));
        tbl.push_back(mk(1, 2, 32'h22,   32'h104, 1, 1, 2,  1, 0, 0, 32'h0,  32'h0,   1, 0, 1));
        tbl.push_back(mk(1, 3, 32'h33,   32'h108, 1, 2, 3,  1, 0, 0, 32'h0,  32'h0,   1, 0, 2));
        tbl.push_back(mk(1, 1, 32'h44,   32'h10c, 1, 3, 4,  1, 0, 0, 32'h0,  32'h0,   1, 0, 3));
        tbl.push_back(mk(1, 5, 32'h55,   32'h0,   1, 1, 5,  0, 0, 0, 32'h0,  32'h0,   1, 0, 4));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   0, 1, 5,  0, 1, 1, 32'h11, 32'h100, 1, 0, 4));
        tbl.push_back(mk(1, 6, 32'h66,   32'h110, 0, 1, 2,  1, 1, 2, 32'h22, 32'h104, 1, 1, 3));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   0, 2, 6,  1, 1, 3, 32'h33, 32'h108, 0, 1, 3));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   1, 1, 3,  1, 0, 0, 32'h0,  32'h0,   1, 0, 2));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   1, 1, 3,  1, 0, 0, 32'h0,  32'h0,   1, 0, 2));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   0, 1, 6,  1, 1, 1, 32'h44, 32'h10c, 1, 1, 2));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   0, 1, 6,  1, 1, 6, 32'h66, 32'h110, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   0, 1, 6,  1, 0, 0, 32'h0,  32'h0,   0, 0, 0));
        tbl.push_back(mk(1, 7, 32'h77,   32'h200, 1, 7, 0,  1, 0, 0, 32'h0,  32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   1, 7, 0,  1, 0, 0, 32'h0,  32'h0,   1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   0, 7, 0,  1, 1, 7, 32'h77, 32'h200, 1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,    32'h0,   0, 7, 0,  1, 0, 0, 32'h0,  32'h0,   0, 0, 0));

        // Reset state
        reset = 1'b0;
        idle(1'b0);
        #12;
        chk("rst_ready", 0, 32'(bus.in_ready), 32'd1);
        chk("rst_we",    0, 32'(bus.gw_we),    32'd0);
        chk("rst_count", 0, 32'(bus.q_count),  32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table walk: inputs at negedge, outputs sampled 1 ns later
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].pc, tbl[i].st, tbl[i].c1, tbl[i].c2);
            #1;
            chk("in_ready",  i, 32'(bus.in_ready),  32'(tbl[i].rdy));
            chk("gw_we",     i, 32'(bus.gw_we),     32'(tbl[i].we));
            chk("gw_addr",   i, 32'(bus.gw_addr),   32'(tbl[i].ga));
            chk("gw_data",   i, bus.gw_data,        tbl[i].gd);
            chk("gw_pc",     i, bus.gw_pc,          tbl[i].gp);
            chk("chk_busy1", i, 32'(bus.chk_busy1), 32'(tbl[i].b1));
            chk("chk_busy2", i, 32'(bus.chk_busy2), 32'(tbl[i].b2));
            chk("q_count",   i, 32'(bus.q_count),   32'(tbl[i].cnt));
        end

`ifndef WBQ_BYPASS_EN
        // Single push: one-cycle latency, then popped
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 32'h3000, 1'b0, 5'd5, 5'd0);
        #1;
        chk("lat_we_same_cycle", 0, 32'(bus.gw_we), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_count",  0, 32'(bus.q_count), 32'd1);
        chk("lat_busy1",  0, 32'(bus.chk_busy1), 32'd1);
        @(negedge clk);
        idle(1'b0);
        #1;
        chk("lat_we",   0, 32'(bus.gw_we),   32'd1);
        chk("lat_addr", 0, 32'(bus.gw_addr), 32'd5);
        chk("lat_data", 0, bus.gw_data,      32'hDEADBEEF);
        chk("lat_pc",   0, bus.gw_pc,        32'h3000);
        @(posedge clk);
        #1;
        chk("lat_count_after", 0, 32'(bus.q_count), 32'd0);
        chk("lat_we_after",    0, 32'(bus.gw_we),   32'd0);
`else
        // Bypass: empty, free port -> same-cycle write, not stored
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h55, 32'h400, 1'b0, 5'd9, 5'd0);
        #1;
        chk("byp_we",    0, 32'(bus.gw_we),     32'd1);
        chk("byp_addr",  0, 32'(bus.gw_addr),   32'd9);
        chk("byp_data",  0, bus.gw_data,        32'h55);
        chk("byp_busy1", 0, 32'(bus.chk_busy1), 32'd0);
        @(posedge clk);
        #1;
        chk("byp_count", 0, 32'(bus.q_count), 32'd0);
        // Stalled port: stored normally
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h56, 32'h404, 1'b1, 5'd9, 5'd0);
        #1;
        chk("byp_stall_we", 0, 32'(bus.gw_we), 32'd0);
        @(posedge clk);
        #1;
        chk("byp_stall_count", 0, 32'(bus.q_count), 32'd1);
        @(negedge clk);
        idle(1'b0);
        #1;
        chk("byp_stall_data", 0, bus.gw_data, 32'h56);
        @(posedge clk);
        #1;
        chk("byp_stall_drain", 0, 32'(bus.q_count), 32'd0);
`endif

        // Reset mid-cycle with three entries queued
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(10 + i), 32'(32'hA0 + i), 32'h500, 1'b1, 5'd10, 5'd12);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd10, 5'd12);
        #1;
        chk("mid_count_before", 0, 32'(bus.q_count), 32'd3);
        chk("mid_we_before",    0, 32'(bus.gw_we),   32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_we",    0, 32'(bus.gw_we),     32'd0);
        chk("mid_count", 0, 32'(bus.q_count),   32'd0);
        chk("mid_ready", 0, 32'(bus.in_ready),  32'd1);
        chk("mid_busy1", 0, 32'(bus.chk_busy1), 32'd0);
        chk("mid_busy2", 0, 32'(bus.chk_busy2), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("post_reset_we", i, 32'(bus.gw_we), 32'd0);
        end

        // First push right after reset release is accepted at the first edge
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'hBEEF, 32'h600, 1'b1, 5'd3, 5'd0);
        @(posedge clk);
        #1;
        chk("first_push_count", 0, 32'(bus.q_count),   32'd1);
        chk("first_push_busy",  0, 32'(bus.chk_busy1), 32'd1);
        @(negedge clk);
        idle(1'b0);
        #1;
        chk("first_push_data", 0, bus.gw_data, 32'hBEEF);
        @(posedge clk);
        #1;
        chk("first_push_drain", 0, 32'(bus.q_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
